// File: rtl/mm_rd_burst_sched_if.sv
// AXI4 read address / read data bundle shared by the burst scheduler and its slave.
interface mm_rd_burst_sched_if #(
    parameter int unsigned ASIZE  = 29,
    parameter int unsigned LSIZE  = 9,
    parameter int unsigned IDSIZE = 4
) ();
    logic [IDSIZE-1:0] arid;
    logic [ASIZE-1:0]  araddr;
    logic [LSIZE-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [IDSIZE-1:0] rid;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rlast, rvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rlast, rvalid
    );
endinterface

// File: rtl/mm_rd_burst_sched.sv
// Multi-channel AXI4 read-burst scheduler: per-channel frame walkers with credit/outstanding
// limits, round-robin AR arbitration, 4 KB burst splitting and rid-steered FIFO write enables.
module mm_rd_burst_sched #(
    parameter int unsigned CH_NUM    = 2,
    parameter int unsigned ASIZE     = 29,
    parameter int unsigned LSIZE     = 9,
    parameter int unsigned IDSIZE    = 4,
    parameter int unsigned ID_BASE   = 0,
    parameter int unsigned AXI_DSIZE = 256,
    parameter int unsigned BURST_LEN = 64,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic [CH_NUM-1:0]       ch_enable_i,
    input  logic [CH_NUM-1:0]       ch_fsync_i,
    input  logic [CH_NUM*ASIZE-1:0] ch_baseaddr_i,
    input  logic [CH_NUM*ASIZE-1:0] ch_stride_i,
    input  logic [CH_NUM*16-1:0]    ch_line_beats_i,
    input  logic [CH_NUM*16-1:0]    ch_lines_i,
    input  logic [CH_NUM*16-1:0]    ch_fifo_free_i,
    output logic [CH_NUM-1:0]       ch_wr_en_o,
    output logic [CH_NUM-1:0]       ch_frame_done_o,
    output logic [CH_NUM-1:0]       ch_busy_o,
    output logic                    rid_err_o,
    mm_rd_burst_sched_if.master     axi
);
    localparam int unsigned BPB = AXI_DSIZE / 8;
    localparam int unsigned ASZ = $clog2(BPB);
    localparam int unsigned CW  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int unsigned OW  = $clog2(MAX_OUTST + 1);
    localparam logic [ASIZE-1:0] AMASK = {ASIZE{1'b1}} << ASZ;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, FLUSH} state_e;

    state_e           state_q [CH_NUM], state_d [CH_NUM];
    logic [ASIZE-1:0] line_addr_q [CH_NUM], line_addr_d [CH_NUM];
    logic [ASIZE-1:0] stride_q [CH_NUM], stride_d [CH_NUM];
    logic [ASIZE-1:0] nbase_q [CH_NUM], nbase_d [CH_NUM];
    logic [ASIZE-1:0] nstride_q [CH_NUM], nstride_d [CH_NUM];
    logic [15:0]      beats_q [CH_NUM], beats_d [CH_NUM];
    logic [15:0]      lines_q [CH_NUM], lines_d [CH_NUM];
    logic [15:0]      nbeats_q [CH_NUM], nbeats_d [CH_NUM];
    logic [15:0]      nlines_q [CH_NUM], nlines_d [CH_NUM];
    logic [15:0]      beat_cnt_q [CH_NUM], beat_cnt_d [CH_NUM];
    logic [15:0]      line_cnt_q [CH_NUM], line_cnt_d [CH_NUM];
    logic [15:0]      reserved_q [CH_NUM], reserved_d [CH_NUM];
    logic [OW-1:0]    outst_q [CH_NUM], outst_d [CH_NUM];
    logic [CH_NUM-1:0] frame_done_q, frame_done_d;
    logic             rid_err_q;

    logic [ASIZE-1:0] addr_c [CH_NUM];
    logic [15:0]      rem_c [CH_NUM], to4k_c [CH_NUM], len_c [CH_NUM];
    logic [CH_NUM-1:0] elig, hit, fs, ar_hs, pend, eol, lastb;

    logic             arvalid_q;
    logic [ASIZE-1:0] araddr_q;
    logic [LSIZE-1:0] arlen_q;
    logic [IDSIZE-1:0] arid_q;
    logic [15:0]      len_q;
    logic [CW-1:0]    gnt_q, last_q, gnt_idx, cand;
    logic             gnt_found;

    logic             beat, hs;
    logic [31:0]      rid_off;

    assign beat    = axi.rvalid & axi.rready;
    assign hs      = arvalid_q & axi.arready;
    assign rid_off = 32'(axi.rid) - ID_BASE;

    always_comb begin : burst_calc
        elig  = '0;
        hit   = '0;
        fs    = '0;
        ar_hs = '0;
        pend  = '0;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            addr_c[c] = line_addr_q[c] + (ASIZE'(beat_cnt_q[c]) << ASZ);
            rem_c[c]  = beats_q[c] - beat_cnt_q[c];
            to4k_c[c] = 16'((13'd4096 - {1'b0, addr_c[c][11:0]}) >> ASZ);
            len_c[c]  = 16'(BURST_LEN);
            if (rem_c[c] < len_c[c]) len_c[c] = rem_c[c];
            if (to4k_c[c] < len_c[c]) len_c[c] = to4k_c[c];
            fs[c]    = ch_fsync_i[c] & ch_enable_i[c];
            // A same-cycle fsync suppresses the grant so no stale-frame burst is queued.
            elig[c]  = (state_q[c] == ACTIVE) && ch_enable_i[c] && !fs[c]
                       && (outst_q[c] < OW'(MAX_OUTST))
                       && ({1'b0, ch_fifo_free_i[c*16 +: 16]} >= ({1'b0, reserved_q[c]} + {1'b0, len_c[c]}));
            hit[c]   = beat && (rid_off == c);
            ar_hs[c] = hs && (gnt_q == CW'(c));
            pend[c]  = arvalid_q && (gnt_q == CW'(c));
        end
    end

    always_comb begin : rr_arb
        gnt_found = 1'b0;
        gnt_idx   = last_q;
        cand      = '0;
        for (int unsigned i = 1; i <= CH_NUM; i++) begin
            cand = CW'((32'(last_q) + i) % CH_NUM);
            if (!gnt_found && elig[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin : credit_calc
        eol   = '0;
        lastb = '0;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            outst_d[c] = outst_q[c];
            if (ar_hs[c] && !(hit[c] && axi.rlast))
                outst_d[c] = outst_q[c] + OW'(1);
            else if (!ar_hs[c] && hit[c] && axi.rlast && outst_q[c] != '0)
                outst_d[c] = outst_q[c] - OW'(1);
            reserved_d[c] = reserved_q[c] + (ar_hs[c] ? len_q : 16'd0);
            if (hit[c] && reserved_d[c] != '0) reserved_d[c] = reserved_d[c] - 16'd1;
            eol[c]   = (beat_cnt_q[c] + len_q) == beats_q[c];
            lastb[c] = eol[c] && ((line_cnt_q[c] + 16'd1) == lines_q[c]);
        end
    end

    always_comb begin : state_next
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            state_d[c] = state_q[c];
            unique case (state_q[c])
                IDLE:    if (fs[c]) state_d[c] = ACTIVE;
                ACTIVE:  if (fs[c]) state_d[c] = FLUSH;
                         else if (ar_hs[c] && lastb[c]) state_d[c] = DRAIN;
                DRAIN:   if (fs[c]) state_d[c] = FLUSH;
                         else if (outst_d[c] == '0) state_d[c] = IDLE;
                // Restart waits for any AR still held on the bus for this channel.
                FLUSH:   if (!fs[c] && outst_d[c] == '0 && !pend[c]) state_d[c] = ACTIVE;
                default: state_d[c] = IDLE;
            endcase
        end
    end

    always_comb begin : chan_next
        frame_done_d = '0;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            line_addr_d[c] = line_addr_q[c];
            stride_d[c]    = stride_q[c];
            beats_d[c]     = beats_q[c];
            lines_d[c]     = lines_q[c];
            beat_cnt_d[c]  = beat_cnt_q[c];
            line_cnt_d[c]  = line_cnt_q[c];
            nbase_d[c]     = nbase_q[c];
            nstride_d[c]   = nstride_q[c];
            nbeats_d[c]    = nbeats_q[c];
            nlines_d[c]    = nlines_q[c];
            if (fs[c]) begin
                nbase_d[c]   = ch_baseaddr_i[c*ASIZE +: ASIZE] & AMASK;
                nstride_d[c] = ch_stride_i[c*ASIZE +: ASIZE] & AMASK;
                nbeats_d[c]  = ch_line_beats_i[c*16 +: 16];
                nlines_d[c]  = ch_lines_i[c*16 +: 16];
            end
            if (state_q[c] == IDLE && fs[c]) begin
                line_addr_d[c] = ch_baseaddr_i[c*ASIZE +: ASIZE] & AMASK;
                stride_d[c]    = ch_stride_i[c*ASIZE +: ASIZE] & AMASK;
                beats_d[c]     = ch_line_beats_i[c*16 +: 16];
                lines_d[c]     = ch_lines_i[c*16 +: 16];
                beat_cnt_d[c]  = '0;
                line_cnt_d[c]  = '0;
            end else if (state_q[c] == FLUSH && state_d[c] == ACTIVE) begin
                line_addr_d[c] = nbase_q[c];
                stride_d[c]    = nstride_q[c];
                beats_d[c]     = nbeats_q[c];
                lines_d[c]     = nlines_q[c];
                beat_cnt_d[c]  = '0;
                line_cnt_d[c]  = '0;
            end else if (state_q[c] == ACTIVE && ar_hs[c]) begin
                if (eol[c]) begin
                    beat_cnt_d[c]  = '0;
                    line_cnt_d[c]  = line_cnt_q[c] + 16'd1;
                    line_addr_d[c] = line_addr_q[c] + stride_q[c];
                end else begin
                    beat_cnt_d[c] = beat_cnt_q[c] + len_q;
                end
            end
            frame_done_d[c] = (state_q[c] == DRAIN) && (state_d[c] == IDLE);
        end
    end

    always_ff @(posedge clock) begin : state_reg
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            if (rst) state_q[c] <= IDLE;
            else     state_q[c] <= state_d[c];
        end
    end

    always_ff @(posedge clock) begin : chan_reg
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            if (rst) begin
                line_addr_q[c] <= '0; stride_q[c]  <= '0; beats_q[c]    <= '0; lines_q[c]    <= '0;
                nbase_q[c]     <= '0; nstride_q[c] <= '0; nbeats_q[c]   <= '0; nlines_q[c]   <= '0;
                beat_cnt_q[c]  <= '0; line_cnt_q[c] <= '0; reserved_q[c] <= '0; outst_q[c]  <= '0;
            end else begin
                line_addr_q[c] <= line_addr_d[c]; stride_q[c]  <= stride_d[c];
                beats_q[c]     <= beats_d[c];     lines_q[c]   <= lines_d[c];
                nbase_q[c]     <= nbase_d[c];     nstride_q[c] <= nstride_d[c];
                nbeats_q[c]    <= nbeats_d[c];    nlines_q[c]  <= nlines_d[c];
                beat_cnt_q[c]  <= beat_cnt_d[c];  line_cnt_q[c] <= line_cnt_d[c];
                reserved_q[c]  <= reserved_d[c];  outst_q[c]   <= outst_d[c];
            end
        end
        if (rst) begin
            frame_done_q <= '0;
            rid_err_q    <= 1'b0;
        end else begin
            frame_done_q <= frame_done_d;
            rid_err_q    <= rid_err_q | (beat & (rid_off >= CH_NUM));
        end
    end

    always_ff @(posedge clock) begin : ar_reg
        if (rst) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arid_q    <= '0;
            len_q     <= '0;
            gnt_q     <= '0;
            last_q    <= CW'(CH_NUM - 1);
        end else if (arvalid_q) begin
            if (axi.arready) arvalid_q <= 1'b0;
        end else if (gnt_found) begin
            arvalid_q <= 1'b1;
            araddr_q  <= addr_c[gnt_idx];
            arlen_q   <= LSIZE'(len_c[gnt_idx] - 16'd1);
            arid_q    <= IDSIZE'(ID_BASE + 32'(gnt_idx));
            len_q     <= len_c[gnt_idx];
            gnt_q     <= gnt_idx;
            last_q    <= gnt_idx;
        end
    end

    always_comb begin : outputs
        ch_busy_o  = '0;
        ch_wr_en_o = '0;
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            ch_busy_o[c]  = state_q[c] != IDLE;
            ch_wr_en_o[c] = hit[c] && (state_q[c] == ACTIVE || state_q[c] == DRAIN);
        end
    end

    assign ch_frame_done_o = frame_done_q;
    assign rid_err_o       = rid_err_q;
    assign axi.arvalid     = arvalid_q;
    assign axi.araddr      = araddr_q;
    assign axi.arlen       = arlen_q;
    assign axi.arid        = arid_q;
    assign axi.arsize      = 3'(ASZ);
    assign axi.arburst     = 2'b01;
    assign axi.rready      = ~rst;
endmodule
